// File: rtl/tt_sequencer.sv
// Exhaustive truth-table sweep: drives every input vector of a small combinational
// function, compares its 1-bit output against EXPECT and reports errors and the first failing index.
module tt_sequencer #(
  parameter int                   N      = 3,
  parameter logic [(1<<N)-1:0]    EXPECT = 8'b1110_0000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         dut_out,
  output logic [N-1:0] vec,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   err_count,
  output logic [N-1:0] first_fail
);

  localparam logic [1:0]   S_IDLE   = 2'd0;
  localparam logic [1:0]   S_APPLY  = 2'd1;
  localparam logic [1:0]   S_SAMPLE = 2'd2;
  localparam logic [1:0]   S_DONE   = 2'd3;
  localparam logic [N-1:0] VEC_LAST = {N{1'b1}};

  logic [1:0]   state_q, state_d;
  logic [N-1:0] vec_q, vec_d;
  logic [N:0]   err_q, err_d;
  logic [N-1:0] ff_q, ff_d;
  logic         mismatch_s;

  // Next-state and datapath update for the sweep FSM.
  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    err_d      = err_q;
    ff_d       = ff_q;
    mismatch_s = dut_out ^ EXPECT[vec_q];
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_APPLY;
          vec_d   = '0;
          err_d   = '0;
          ff_d    = '0;
        end else begin
          state_d = state_q;
        end
      end
      S_APPLY: begin
        state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (mismatch_s) begin
          err_d = err_q + (N+1)'(1);
          if (err_q == '0) begin
            ff_d = vec_q;
          end else begin
            ff_d = ff_q;
          end
        end else begin
          err_d = err_q;
        end
        // The terminal index ends the sweep; vec never wraps.
        if (vec_q == VEC_LAST) begin
          state_d = S_DONE;
        end else begin
          vec_d   = vec_q + N'(1);
          state_d = S_APPLY;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      err_q   <= '0;
      ff_q    <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
    end
  end

  assign vec        = vec_q;
  assign err_count  = err_q;
  assign first_fail = ff_q;
  assign busy       = (state_q == S_APPLY) || (state_q == S_SAMPLE);
  assign done       = (state_q == S_DONE);
  assign pass       = (state_q == S_DONE) && (err_q == '0);

endmodule

// File: tb/tb_tt_sequencer.sv
// Directed bench for tt_sequencer: a model function with selectable faults feeds dut_out.
module tb_tt_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic       dut_out;
  logic [2:0] vec;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_count;
  logic [2:0] first_fail;

  int checks;
  int failures;
  int mode;  // 0 correct, 1 stuck0, 2 stuck1, 3 inverted

  tt_sequencer #(.N(3), .EXPECT(8'b1110_0000)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .dut_out    (dut_out),
    .vec        (vec),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .first_fail (first_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Function under test: x = a & (b | c), with vec = {a,b,c}.
  always_comb begin
    case (mode)
      0:       dut_out = vec[2] & (vec[1] | vec[0]);
      1:       dut_out = 1'b0;
      2:       dut_out = 1'b1;
      3:       dut_out = ~(vec[2] & (vec[1] | vec[0]));
      default: dut_out = 1'b0;
    endcase
  end

  // Pulse start for one edge; returns just after the start edge (edge 0).
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts edges after edge 0 until done, bounded.
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!done && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    mode  = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({vec, busy, done, pass, err_count, first_fail} !== 13'd0) begin
      failures++;
      $display("FAIL reset_outputs: got vec=%0d busy=%0b done=%0b pass=%0b err=%0d ff=%0d, want all 0",
               vec, busy, done, pass, err_count, first_fail);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle_hold: got busy=%0b done=%0b, want 0 0", busy, done);
    end
  endtask

  task automatic test_correct();
    mode = 0;
    pulse_start();
    for (int c = 0; c < 16; c++) begin
      checks++;
      if (vec !== 3'(c / 2) || busy !== 1'b1 || done !== 1'b0) begin
        failures++;
        $display("FAIL correct_step%0d: got vec=%0d busy=%0b done=%0b, want vec=%0d busy=1 done=0",
                 c, vec, busy, done, c / 2);
      end
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || pass !== 1'b1 || err_count !== 4'd0 || first_fail !== 3'd0) begin
      failures++;
      $display("FAIL correct_result: got done=%0b busy=%0b pass=%0b err=%0d ff=%0d, want 1 0 1 0 0",
               done, busy, pass, err_count, first_fail);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || vec !== 3'd7) begin
      failures++;
      $display("FAIL correct_hold: got done=%0b vec=%0d, want 1 7", done, vec);
    end
  endtask

  task automatic test_faults();
    int cyc;
    int exp_err [4];
    int exp_ff  [4];
    exp_err = '{0, 3, 5, 8};
    exp_ff  = '{0, 5, 0, 0};
    for (int m = 1; m < 4; m++) begin
      mode = m;
      pulse_start();
      wait_done(cyc);
      checks++;
      if (cyc != 16 || err_count !== 4'(exp_err[m]) || first_fail !== 3'(exp_ff[m]) || pass !== 1'b0) begin
        failures++;
        $display("FAIL fault_mode%0d: got cycles=%0d err=%0d ff=%0d pass=%0b, want 16 %0d %0d 0",
                 m, cyc, err_count, first_fail, pass, exp_err[m], exp_ff[m]);
      end
    end
  endtask

  task automatic test_start_ignored();
    int cyc;
    mode = 0;
    pulse_start();
    start = 1'b1;  // sampled at edge 1, state APPLY
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (vec !== 3'd0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL ignore_apply: got vec=%0d busy=%0b, want 0 1", vec, busy);
    end
    start = 1'b1;  // sampled at edge 2, state SAMPLE
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (vec !== 3'd1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL ignore_sample: got vec=%0d busy=%0b, want 1 1", vec, busy);
    end
    wait_done(cyc);
    checks++;
    if (cyc + 2 != 16 || pass !== 1'b1) begin
      failures++;
      $display("FAIL ignore_latency: got cycles=%0d pass=%0b, want 16 1", cyc + 2, pass);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    mode = 3;
    pulse_start();
    repeat (8) @(negedge clk);
    checks++;
    if (vec !== 3'd4 || err_count !== 4'd4) begin
      failures++;
      $display("FAIL midreset_pre: got vec=%0d err=%0d, want 4 4", vec, err_count);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({vec, busy, done, pass, err_count, first_fail} !== 13'd0) begin
      failures++;
      $display("FAIL midreset_clear: got vec=%0d busy=%0b done=%0b pass=%0b err=%0d ff=%0d, want all 0",
               vec, busy, done, pass, err_count, first_fail);
    end
    mode = 0;
    pulse_start();
    wait_done(cyc);
    checks++;
    if (cyc != 16 || err_count !== 4'd0 || pass !== 1'b1) begin
      failures++;
      $display("FAIL midreset_rerun: got cycles=%0d err=%0d pass=%0b, want 16 0 1", cyc, err_count, pass);
    end
  endtask

  task automatic test_restart();
    int cyc;
    mode = 1;
    pulse_start();
    wait_done(cyc);
    checks++;
    if (err_count !== 4'd3 || pass !== 1'b0) begin
      failures++;
      $display("FAIL restart_first: got err=%0d pass=%0b, want 3 0", err_count, pass);
    end
    mode = 0;
    pulse_start();
    checks++;
    if (err_count !== 4'd0 || first_fail !== 3'd0 || vec !== 3'd0 || busy !== 1'b1 || done !== 1'b0 || pass !== 1'b0) begin
      failures++;
      $display("FAIL restart_clear: got err=%0d ff=%0d vec=%0d busy=%0b done=%0b pass=%0b, want 0 0 0 1 0 0",
               err_count, first_fail, vec, busy, done, pass);
    end
    wait_done(cyc);
    checks++;
    if (cyc != 16 || pass !== 1'b1 || err_count !== 4'd0) begin
      failures++;
      $display("FAIL restart_final: got cycles=%0d pass=%0b err=%0d, want 16 1 0", cyc, pass, err_count);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    start    = 1'b0;
    mode     = 0;
    test_reset();
    test_correct();
    test_faults();
    test_start_ignored();
    test_reset_mid();
    test_restart();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tt_sequencer.md
# tt_sequencer

Exhaustive truth-table sequencer and checker for small combinational gate functions. It sits directly upstream of the function under test, driving its input vector. It also consumes the function's 1-bit output and compares each result against a parameterised expected truth table. It replaces hand-written `#1` stimulus lists with a clocked, self-checking sweep that reports pass/fail, error count and first failing index.

## Interface
Parameters:
- `N`, 3: number of function inputs; vector width. Legal range 1..6.
- `EXPECT`, 8'b1110_0000: expected output per input index, width 2^N. Bit i is the expected result for `vec == i`. The default encodes x = a & (b | c) with `vec = {a,b,c}`.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `start`, input, 1: begin a sweep; sampled only in IDLE or DONE.
- `dut_out`, input, 1: output of the function under test, combinational from `vec`.
- `vec`, output, N: input vector driven to the function under test.
- `busy`, output, 1: high in APPLY and SAMPLE.
- `done`, output, 1: high in DONE.
- `pass`, output, 1: high in DONE when `err_count == 0`; low in all other states.
- `err_count`, output, N+1: number of mismatches in the current or last sweep. Saturation is never needed, because the maximum count is 2^N.
- `first_fail`, output, N: index of the first mismatch. Holds 0 while `err_count == 0`.

## Operation
- The FSM has four states: IDLE, APPLY, SAMPLE, DONE.
- **IDLE:**
  - `start = 1` → APPLY.
  - At the same time: `vec` ← 0, `err_count` ← 0, `first_fail` ← 0.
- **APPLY:** settle cycle; `vec` is held stable. Unconditionally → SAMPLE.
- **SAMPLE:** compute `mismatch = dut_out ^ EXPECT[vec]`.
  - On mismatch: `err_count` ← `err_count + 1`.
  - If this is the first mismatch (`err_count == 0`), `first_fail` ← `vec`.
  - If `vec == 2^N − 1` → DONE, and `vec` holds its last value.
  - Otherwise `vec` ← `vec + 1` → APPLY.
- **DONE:** results are held.
  - `start = 1` → APPLY, with the same clears as from IDLE (restart).
  - Otherwise stay in DONE.
- `start` is ignored in APPLY and SAMPLE; a sweep cannot be interrupted except by `reset`.
- `vec` never wraps during a sweep; the terminal index ends the sweep.
- `dut_out` is compared only in SAMPLE; its value in other states is don't-care.

## Timing
- Reset value of every output: `vec` = 0, `busy` = 0, `done` = 0, `pass` = 0, `err_count` = 0, `first_fail` = 0. State after reset is IDLE.
- `reset` asserted at any point, including mid-sweep, returns the block to IDLE with those values at the next edge. Reset has priority over `start`.
- Edge numbering: edge 0 is the rising edge that samples `start = 1`.
  - After edge 2k: APPLY with `vec = k`.
  - After edge 2k+1: SAMPLE with `vec = k`.
  - Mismatch for index k is registered at edge 2k+2.
- Latency: `done` rises after edge 2^(N+1), i.e. 16 cycles for N = 3.
  - `busy` is high for exactly 2^(N+1) cycles.
  - `busy` and `done` are never high together.
- Each vector is held for 2 cycles. `dut_out` must settle within one cycle of a `vec` change.
- All outputs are registered or decoded from the state register; there are no combinational paths from `dut_out` to outputs.

## Test plan
- Correct model, x = a & (b | c), default parameters, pulse `start`:
  - `vec` steps 0..7 with each value held 2 cycles.
  - `done` rises 16 edges after the start edge.
  - Result: `pass` = 1, `err_count` = 0, `first_fail` = 0.
- `dut_out` stuck at 0 → `err_count` = 3, `first_fail` = 5, `pass` = 0.
- `dut_out` stuck at 1 → `err_count` = 5, `first_fail` = 0. Inverted model → `err_count` = 8, `first_fail` = 0.
- `start` pulsed in APPLY and again in SAMPLE mid-sweep → no effect; `done` still rises 16 edges after the original start.
- `reset` asserted for 1 cycle when `vec` = 4 → next edge: all outputs 0, state IDLE. A new `start` then gives a full 16-cycle sweep with a clean count.
- Restart from DONE after a failing run (stuck at 0), with the model now correct → `err_count` cleared at the restart edge; final `pass` = 1.
